// File: rtl/tx_pkg.sv
// -----------------------------------------------------------------------------
// tx_pkg
// Shared definitions for the parametrised serial transmitter (tx_frame).
//   tx_state_t : FSM state encoding (IDLE, START, DATA, PARITY, STOP), kept as
//                plain 3-bit constants so existing tools and dumps decode them
//                the same way as the fixed 8-bit transmitter.
//   TX_MARK    : idle / stop-bit line level (1).
//   TX_SPACE   : start-bit line level (0).
// -----------------------------------------------------------------------------
package tx_pkg;

  typedef logic [2:0] tx_state_t;

  localparam tx_state_t IDLE   = 3'd0;
  localparam tx_state_t START  = 3'd1;
  localparam tx_state_t DATA   = 3'd2;
  localparam tx_state_t PARITY = 3'd3;
  localparam tx_state_t STOP   = 3'd4;

  localparam logic TX_MARK  = 1'b1;
  localparam logic TX_SPACE = 1'b0;

endpackage

// File: rtl/tx_frame_if.sv
// -----------------------------------------------------------------------------
// tx_frame_if
// Bundles the request/serial-line signals between the transmit-side
// controller (master) and the tx_frame transmitter (slave).
//   tx_start : start request (master -> slave)
//   tx_pi    : parallel data word, DATA_WIDTH bits (master -> slave)
//   tx_so    : serial line, idles high (slave -> master / link)
//   tx_busy  : frame in progress (slave -> master)
//   tx_done  : one-cycle end-of-frame pulse (slave -> master)
// -----------------------------------------------------------------------------
interface tx_frame_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_pi;
  logic                  tx_so;
  logic                  tx_busy;
  logic                  tx_done;

  modport master (
    output tx_start,
    output tx_pi,
    input  tx_so,
    input  tx_busy,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_pi,
    output tx_so,
    output tx_busy,
    output tx_done
  );

endinterface

// File: rtl/tx_baud_cnt.sv
// -----------------------------------------------------------------------------
// tx_baud_cnt
// Bit-period timer for tx_frame. Counts 0..CLKS_PER_BIT-1 and flags the
// terminal count, which ends the current bit.
//   clk     : system clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear   : hold the count at zero (used while the transmitter is idle)
//   bit_end : high in the last clock of each bit period
// -----------------------------------------------------------------------------
module tx_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  // A one-clock bit period still needs a 1-bit register to exist.
  localparam int             CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // With CLKS_PER_BIT=1 the terminal count is 0, so every active clock ends a bit.
  assign bit_end = !clear && (cnt == TERM);

endmodule

// File: rtl/tx_frame.sv
// -----------------------------------------------------------------------------
// tx_frame
// Parametrised asynchronous serial transmitter. On an accepted start request
// it sends: start bit (0), DATA_WIDTH data bits (MSB or LSB first), an
// optional parity bit, then STOP_BITS stop bits (1). Each bit lasts
// CLKS_PER_BIT clocks. All outputs are registered.
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset; abandons any frame in flight
//   bus   : tx_frame_if.slave
//             tx_start (in)  start request, sampled only while idle
//             tx_pi    (in)  data word, captured when tx_start is accepted
//             tx_so    (out) serial line, idles at mark (1)
//             tx_busy  (out) high for the whole frame
//             tx_done  (out) one-cycle pulse after the last stop-bit cycle
//
// Parameters: DATA_WIDTH (5..16), CLKS_PER_BIT (>=1), STOP_BITS (1 or 2),
//             MSB_FIRST (1 = MSB first), PARITY_ODD (1 = odd parity).
//
// Build option: define TX_PARITY_EN to add the parity bit after the data
// bits. Without it there is no parity logic and PARITY_ODD has no effect.
// -----------------------------------------------------------------------------
module tx_frame
  import tx_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  tx_frame_if.slave   bus
);

  localparam int               BIT_W     = $clog2(DATA_WIDTH + 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] shreg_nxt;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  bit_end;
  logic                  baud_clr;
  logic                  so_q;
  logic                  busy_q;
  logic                  done_q;
`ifdef TX_PARITY_EN
  logic                  par_bit;
`endif

  // Bit that goes on the line next for a given shift-register content.
  function automatic logic head_bit(input logic [DATA_WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[DATA_WIDTH-1] : v[0];
  endfunction

  // Timer is held at zero while idle so the start bit always gets a full period.
  assign baud_clr = (state == IDLE);

  tx_baud_cnt #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (baud_clr),
    .bit_end (bit_end)
  );

  assign shreg_nxt = (MSB_FIRST != 0) ? {shreg[DATA_WIDTH-2:0], 1'b0}
                                      : {1'b0, shreg[DATA_WIDTH-1:1]};

  // tx_so is loaded with the level of the bit about to start, so the line
  // changes on the same edge as the state and never passes through logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      so_q    <= TX_MARK;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_PARITY_EN
      par_bit <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.tx_start) begin
            shreg   <= bus.tx_pi;
            bit_cnt <= '0;
            state   <= START;
            so_q    <= TX_SPACE;
            busy_q  <= 1'b1;
`ifdef TX_PARITY_EN
            // Parity of the captured word, fixed for the whole frame.
            par_bit <= (^bus.tx_pi) ^ (PARITY_ODD != 0);
`endif
          end
        end

        START: begin
          if (bit_end) begin
            state <= DATA;
            so_q  <= head_bit(shreg);
          end
        end

        DATA: begin
          if (bit_end) begin
            shreg <= shreg_nxt;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
`ifdef TX_PARITY_EN
              state   <= PARITY;
              so_q    <= par_bit;
`else
              state   <= STOP;
              so_q    <= TX_MARK;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              so_q    <= head_bit(shreg_nxt);
            end
          end
        end

`ifdef TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            so_q  <= TX_MARK;
          end
        end
`endif

        // bit_cnt is reused to count stop bits.
        STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              bit_cnt <= '0;
              state   <= IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end

        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          so_q    <= TX_MARK;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_so   = so_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_tx_frame.sv
`timescale 1ns/1ps
module tb_tx_frame;

  localparam int N_DUT = 3;
`ifdef TX_PARITY_EN
  localparam bit P_EN = 1'b1;
`else
  localparam bit P_EN = 1'b0;
`endif

  // Frame as seen on the line: bits[i] is the i-th bit period, n bit periods.
  typedef struct packed {
    logic [31:0] bits;
    logic [7:0]  n;
  } frame_t;

  // Configurations of the three instances.
  int dw_a   [N_DUT] = '{8, 8, 5};
  int cpb_a  [N_DUT] = '{4, 4, 1};
  int sb_a   [N_DUT] = '{1, 2, 1};
  int msb_a  [N_DUT] = '{1, 0, 1};
  int podd_a [N_DUT] = '{0, 1, 0};

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];

  tx_frame_if #(.DATA_WIDTH(8)) if0 ();
  tx_frame_if #(.DATA_WIDTH(8)) if1 ();
  tx_frame_if #(.DATA_WIDTH(5)) if2 ();

  tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .MSB_FIRST(1), .PARITY_ODD(0))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  tx_frame #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(2), .MSB_FIRST(0), .PARITY_ODD(1))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  tx_frame #(.DATA_WIDTH(5), .CLKS_PER_BIT(1), .STOP_BITS(1), .MSB_FIRST(1), .PARITY_ODD(0))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // {tx_so, tx_busy, tx_done}
  function automatic logic [2:0] outs(input int k);
    case (k)
      0:       return {if0.tx_so, if0.tx_busy, if0.tx_done};
      1:       return {if1.tx_so, if1.tx_busy, if1.tx_done};
      default: return {if2.tx_so, if2.tx_busy, if2.tx_done};
    endcase
  endfunction

  task automatic set_in(input int k, input logic st, input logic [15:0] d);
    case (k)
      0:       begin if0.tx_start = st; if0.tx_pi = d[7:0]; end
      1:       begin if1.tx_start = st; if1.tx_pi = d[7:0]; end
      default: begin if2.tx_start = st; if2.tx_pi = d[4:0]; end
    endcase
  endtask

  function automatic void push(input int k, input frame_t f);
    case (k)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endfunction

  function automatic frame_t qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Expected frame from a bit string written in transmission order.
  function automatic frame_t fr(input string body, input string par, input string stop);
    string  s;
    frame_t f;
    s = P_EN ? {body, par, stop} : {body, stop};
    f.bits = '0;
    f.n    = 8'(s.len());
    for (int i = 0; i < s.len(); i++) f.bits[i] = (s[i] == 8'h31);
    return f;
  endfunction

  // Reference model: start, data in configured order, optional parity, stops.
  function automatic frame_t model(input int k, input logic [15:0] d);
    frame_t f;
    int     n;
    int     ones;
    f.bits = '0;
    n = 0;
    f.bits[n] = 1'b0;
    n++;
    ones = 0;
    for (int i = 0; i < dw_a[k]; i++) begin
      f.bits[n] = (msb_a[k] != 0) ? d[dw_a[k]-1-i] : d[i];
      ones += int'(d[i]);
      n++;
    end
    if (P_EN) begin
      f.bits[n] = ((ones % 2) == 1) ^ (podd_a[k] != 0);
      n++;
    end
    for (int i = 0; i < sb_a[k]; i++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.n = 8'(n);
    return f;
  endfunction

  // Called on a falling edge; waits until the instance is idle, optionally
  // scribbling on its inputs meanwhile, then issues a one-cycle start.
  task automatic send(input int k, input logic [15:0] d, input frame_t f,
                      input bit junk, input int gap);
    logic [2:0] o;
    int         w;
    o = outs(k);
    w = 0;
    while (o[1] && w < 400) begin
      if (junk) set_in(k, 1'($urandom_range(0, 1)), 16'($urandom));
      @(negedge clk);
      o = outs(k);
      w++;
    end
    set_in(k, 1'b0, 16'($urandom));
    if (o[1]) check($sformatf("d%0d_idle_timeout", k), 32'(o[1]), 32'd0);
    repeat (gap) @(negedge clk);
    push(k, f);
    set_in(k, 1'b1, d);
    @(negedge clk);
    set_in(k, 1'b0, junk ? 16'($urandom) : d);
  endtask

  task automatic wait_idle_all();
    int w;
    w = 0;
    while ((outs(0)[1] | outs(1)[1] | outs(2)[1]) && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) check("idle_all_timeout", 32'd1, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // Monitor: whenever an instance goes busy, pop the expected frame and
  // compare every cycle of it, then the tx_done cycle.
  task automatic mon(input int k);
    frame_t      f;
    logic [2:0]  o;
    logic [31:0] got;
    logic        steady;
    logic        flags_ok;
    logic        aborted;
    int          cpb;
    int          len;
    int          bi;
    cpb = cpb_a[k];
    forever begin
      @(negedge clk);
      o = outs(k);
      if (rst_n && o[1]) begin
        if (qsize(k) == 0) begin
          check($sformatf("d%0d_unexpected_frame", k), 32'(o), 32'b100);
          for (int w = 0; w < 300 && o[1]; w++) begin
            @(negedge clk);
            o = outs(k);
          end
        end else begin
          f        = qpop(k);
          len      = int'(f.n) * cpb;
          got      = '0;
          steady   = 1'b1;
          flags_ok = 1'b1;
          aborted  = 1'b0;
          for (int c = 0; c < len; c++) begin
            if (c > 0) begin
              @(negedge clk);
              o = outs(k);
            end
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            bi = c / cpb;
            if ((c % cpb) == 0) got[bi] = o[2];
            else if (o[2] !== got[bi]) steady = 1'b0;
            if (o[1:0] !== 2'b10) flags_ok = 1'b0;
          end
          if (!aborted) begin
            check($sformatf("d%0d_frame_bits", k), got, f.bits);
            check($sformatf("d%0d_busy_steady", k), {30'd0, steady, flags_ok}, 32'b11);
            @(negedge clk);
            o = outs(k);
            if (rst_n) check($sformatf("d%0d_done_cycle", k), 32'(o), 32'b101);
          end
        end
      end
    end
  endtask

  initial begin
    fork
      mon(0);
      mon(1);
      mon(2);
    join_none
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  o;
    logic [15:0] d;
    int          w;
    for (int k = 0; k < N_DUT; k++) set_in(k, 1'b0, 16'd0);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check($sformatf("d%0d_reset", k), 32'(outs(k)), 32'b100);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed frames from known bit patterns.
    send(0, 16'hA5, fr("010100101", "0", "1"), 1'b0, 1);
    send(1, 16'hA5, fr("010100101", "1", "11"), 1'b0, 1);
    send(1, 16'h01, fr("010000000", "0", "11"), 1'b0, 1);
    send(2, 16'h15, fr("010101", "1", "1"), 1'b0, 1);

    // Requests and data changes during a frame are ignored.
    send(0, 16'h5A, fr("001011010", "0", "1"), 1'b0, 1);
    repeat (8) @(negedge clk);
    set_in(0, 1'b1, 16'hFF);
    o = outs(0);
    w = 0;
    while (o[1] && w < 300) begin
      @(negedge clk);
      o = outs(0);
      w++;
    end
    set_in(0, 1'b0, 16'hFF);
    check("d0_ignored_req_end", 32'(o[1]), 32'd0);
    repeat (12) @(negedge clk);

    // Start held in the done cycle: next start bit follows one mark cycle.
    send(0, 16'hC3, fr("011000011", "0", "1"), 1'b0, 1);
    o = outs(0);
    w = 0;
    while (!o[0] && w < 300) begin
      @(negedge clk);
      o = outs(0);
      w++;
    end
    check("d0_b2b_done_seen", 32'(o[0]), 32'd1);
    push(0, fr("010010110", "0", "1"));
    set_in(0, 1'b1, 16'h96);
    @(negedge clk);
    set_in(0, 1'b0, 16'h00);
    check("d0_b2b_start_next", 32'(outs(0)), 32'b010);

    // Reset during data bit 3 (cycles 16..19 of the frame).
    wait_idle_all();
    send(0, 16'h00, fr("000000000", "0", "1"), 1'b0, 0);
    repeat (17) @(negedge clk);
    check("d0_pre_reset_line", 32'(outs(0)), 32'b010);
    #2 rst_n = 1'b0;
    #1 check("d0_async_reset", 32'(outs(0)), 32'b100);
    repeat (2) @(negedge clk);
    check("d0_reset_held", 32'(outs(0)), 32'b100);
    rst_n = 1'b1;
    @(negedge clk);
    send(0, 16'h3C, fr("000111100", "0", "1"), 1'b0, 1);

    // Randomised frames with input noise while busy and random gaps.
    for (int k = 0; k < N_DUT; k++) begin
      for (int i = 0; i < 15; i++) begin
        d = 16'($urandom) & 16'((1 << dw_a[k]) - 1);
        send(k, d, model(k, d), 1'b1, int'($urandom_range(0, 2)));
      end
    end

    wait_idle_all();
    repeat (5) @(negedge clk);
    for (int k = 0; k < N_DUT; k++) check($sformatf("d%0d_queue_empty", k), 32'(qsize(k)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
